// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types, parity mode constants and baud helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int clks_per_bit(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period counter with synchronous restart and terminal tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_tick
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (restart || (r_count == CNT_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bit_tick = (r_count == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_engine
//  Description : Pops bytes from a FWFT FIFO and serialises them as UART frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 460_800,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_read,
    output logic       tx,
    output logic       busy
);

    localparam int         CLKS_PER_BIT = clks_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam logic [2:0] STOP_LAST    = 3'(STOP_BITS - 1);
    localparam logic       PARITY_ON    = (PARITY != PARITY_NONE);
    localparam logic       PARITY_INV   = (PARITY == PARITY_ODD);

    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
        $error("uart_tx_engine: STOP_BITS must be 1 or 2");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
        $error("uart_tx_engine: PARITY must be 0, 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_engine: CLOCK_RATE / BAUD_RATE must be at least 2");
    end

    tx_state_t  r_state,   w_state_next;
    logic [7:0] r_shift,   w_shift_next;
    logic [2:0] r_bit_cnt, w_bit_cnt_next;
    logic       r_parity,  w_parity_next;
    logic       r_tx,      w_tx_next;
    logic       r_busy,    w_busy_next;
    logic       w_pop;
    logic       w_can_pop;
    logic       w_bit_tick;

    // Reset gates the pop so the FIFO is never touched while the engine is held.
    assign w_can_pop = reset & enable & ~fifo_empty;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .reset    (reset),
        .restart  (w_pop),
        .bit_tick (w_bit_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_parity  <= w_parity_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_parity_next  = r_parity;
        w_tx_next      = r_tx;
        w_busy_next    = r_busy;
        w_pop          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
                if (w_can_pop) begin
                    w_pop          = 1'b1;
                    w_shift_next   = fifo_data;
                    w_bit_cnt_next = '0;
                    w_tx_next      = 1'b0;
                    w_busy_next    = 1'b1;
                    w_state_next   = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_tick) begin
                    // Parity taken from the latched byte before shifting begins.
                    w_parity_next = (^r_shift) ^ PARITY_INV;
                    w_tx_next     = r_shift[0];
                    w_state_next  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_cnt_next = '0;
                        if (PARITY_ON) begin
                            w_tx_next    = r_parity;
                            w_state_next = ST_PARITY;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_state_next = ST_STOP;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                        w_tx_next      = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_tick) begin
                    w_bit_cnt_next = '0;
                    w_tx_next      = 1'b1;
                    w_state_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_tick) begin
                    if (r_bit_cnt == STOP_LAST) begin
                        w_bit_cnt_next = '0;
                        if (w_can_pop) begin
                            w_pop        = 1'b1;
                            w_shift_next = fifo_data;
                            w_tx_next    = 1'b0;
                            w_state_next = ST_START;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_busy_next  = 1'b0;
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign fifo_read = w_pop;
    assign tx        = r_tx;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_engine
//  Description : Directed self-checking bench for uart_tx_engine (10 clk/bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

    localparam int BIT = 10;

    logic       clk;
    logic       reset;
    logic [3:0] en;
    logic [3:0] emp;
    logic [3:0] fr;
    logic [3:0] txl;
    logic [3:0] bsy;
    logic [7:0] dat [4];

    logic [7:0] mem [4][16];
    logic [3:0] wr  [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] rd  [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    int         npop[4] = '{0, 0, 0, 0};
    int         bad [4] = '{0, 0, 0, 0};
    int         last_pop[4] = '{0, 0, 0, 0};
    int         cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    assign emp[0] = (wr[0] == rd[0]);
    assign emp[1] = (wr[1] == rd[1]);
    assign emp[2] = (wr[2] == rd[2]);
    assign emp[3] = (wr[3] == rd[3]);
    assign dat[0] = mem[0][rd[0]];
    assign dat[1] = mem[1][rd[1]];
    assign dat[2] = mem[2][rd[2]];
    assign dat[3] = mem[3][rd[3]];

    uart_tx_engine #(.CLOCK_RATE(1000), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .enable(en[0]), .fifo_data(dat[0]), .fifo_empty(emp[0]),
        .fifo_read(fr[0]), .tx(txl[0]), .busy(bsy[0]));
    uart_tx_engine #(.CLOCK_RATE(1000), .BAUD_RATE(100), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .enable(en[1]), .fifo_data(dat[1]), .fifo_empty(emp[1]),
        .fifo_read(fr[1]), .tx(txl[1]), .busy(bsy[1]));
    uart_tx_engine #(.CLOCK_RATE(1000), .BAUD_RATE(100), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset(reset), .enable(en[2]), .fifo_data(dat[2]), .fifo_empty(emp[2]),
        .fifo_read(fr[2]), .tx(txl[2]), .busy(bsy[2]));
    uart_tx_engine #(.CLOCK_RATE(1000), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .reset(reset), .enable(en[3]), .fifo_data(dat[3]), .fifo_empty(emp[3]),
        .fifo_read(fr[3]), .tx(txl[3]), .busy(bsy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT FIFO models: pop on the clock edge that ends a fifo_read cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 4; k++) begin
            if (fr[k]) begin
                rd[k]       <= rd[k] + 4'd1;
                npop[k]     <= npop[k] + 1;
                last_pop[k] <= cyc;
                if (wr[k] == rd[k]) bad[k] <= bad[k] + 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] b);
        mem[k][wr[k]] = b;
        wr[k] = wr[k] + 4'd1;
    endtask

    function automatic logic [11:0] exp_frame(input logic [7:0] b, input int par);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
        if (par == 1) f[9] = ^b;
        if (par == 2) f[9] = ~(^b);
        return f;
    endfunction

    // Leaves the caller inside the pop cycle (between the negedge and posedge).
    task automatic wait_pop(input int k, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (fr[k]) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val({tag, " pop seen"}, {31'd0, found}, 32'd1);
    endtask

    task automatic capture(input int k, input int nbits, input int drop_at,
                           output logic [11:0] bits, output int unstable, output int busy_cnt);
        bits = '1;
        unstable = 0;
        busy_cnt = 0;
        for (int j = 0; j < nbits * BIT; j++) begin
            @(negedge clk);
            if (bsy[k]) busy_cnt++;
            if ((j % BIT) == 0) bits[j / BIT] = txl[k];
            else if (txl[k] !== bits[j / BIT]) unstable++;
            if ((drop_at != 0) && (j == drop_at)) en[k] = 1'b0;
        end
    endtask

    logic [11:0] bits;
    int          unst, bcnt, p0, c0, lowc;

    initial begin
        reset = 1'b0;
        en    = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        check_val("reset tx",   {31'd0, txl[0]}, 32'd1);
        check_val("reset busy", {31'd0, bsy[0]}, 32'd0);
        push(0, 8'h55);
        en[0] = 1'b1;
        #1;
        check_val("reset fifo_read gated", {31'd0, fr[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 0x55 8N1
        c0 = npop[0];
        wait_pop(0, "55");
        check_val("55 busy before start", {31'd0, bsy[0]}, 32'd0);
        capture(0, 10, 0, bits, unst, bcnt);
        check_val("55 frame", {20'd0, bits}, {20'd0, exp_frame(8'h55, 0)});
        check_val("55 bit hold", unst, 0);
        check_val("55 busy cycles", bcnt, 100);
        @(negedge clk);
        check_val("55 busy after", {31'd0, bsy[0]}, 32'd0);
        check_val("55 tx idle", {31'd0, txl[0]}, 32'd1);
        check_val("55 pop count", npop[0] - c0, 1);

        // 0xA3 then 0x0F back to back
        push(0, 8'hA3);
        push(0, 8'h0F);
        c0 = npop[0];
        wait_pop(0, "A3");
        capture(0, 10, 0, bits, unst, bcnt);
        p0 = last_pop[0];
        check_val("A3 byte", {24'd0, bits[8:1]}, 32'h0000_00A3);
        check_val("A3 frame", {20'd0, bits}, {20'd0, exp_frame(8'hA3, 0)});
        check_val("A3 busy cycles", bcnt, 100);
        check_val("A3 last stop pop", {31'd0, fr[0]}, 32'd1);
        capture(0, 10, 0, bits, unst, bcnt);
        check_val("0F byte", {24'd0, bits[8:1]}, 32'h0000_000F);
        check_val("0F frame", {20'd0, bits}, {20'd0, exp_frame(8'h0F, 0)});
        check_val("b2b bit hold", unst, 0);
        check_val("0F busy cycles", bcnt, 100);
        check_val("b2b pop spacing", last_pop[0] - p0, 100);
        check_val("b2b pop count", npop[0] - c0, 2);
        @(negedge clk);
        check_val("b2b busy after", {31'd0, bsy[0]}, 32'd0);

        // 0x07 with even and odd parity
        push(1, 8'h07);
        en[1] = 1'b1;
        wait_pop(1, "even");
        capture(1, 11, 0, bits, unst, bcnt);
        check_val("even parity bit", {31'd0, bits[9]}, 32'd1);
        check_val("even frame", {20'd0, bits}, {20'd0, exp_frame(8'h07, 1)});
        check_val("even busy cycles", bcnt, 110);
        @(negedge clk);
        check_val("even busy after", {31'd0, bsy[1]}, 32'd0);
        push(2, 8'h07);
        en[2] = 1'b1;
        wait_pop(2, "odd");
        capture(2, 11, 0, bits, unst, bcnt);
        check_val("odd parity bit", {31'd0, bits[9]}, 32'd0);
        check_val("odd frame", {20'd0, bits}, {20'd0, exp_frame(8'h07, 2)});
        check_val("odd busy cycles", bcnt, 110);
        check_val("parity bit hold", unst, 0);

        // 0xFF with two stop bits
        push(3, 8'hFF);
        en[3] = 1'b1;
        wait_pop(3, "stop2");
        capture(3, 11, 0, bits, unst, bcnt);
        check_val("stop2 frame", {20'd0, bits}, {20'd0, exp_frame(8'hFF, 0)});
        check_val("stop2 bit hold", unst, 0);
        check_val("stop2 busy cycles", bcnt, 110);
        @(negedge clk);
        check_val("stop2 busy after", {31'd0, bsy[3]}, 32'd0);
        check_val("stop2 tx idle", {31'd0, txl[3]}, 32'd1);

        // enable dropped during data bit 3 with 0x11 queued
        push(0, 8'h3C);
        push(0, 8'h11);
        c0 = npop[0];
        wait_pop(0, "3C");
        capture(0, 10, 44, bits, unst, bcnt);
        check_val("3C frame", {20'd0, bits}, {20'd0, exp_frame(8'h3C, 0)});
        check_val("3C busy cycles", bcnt, 100);
        lowc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (txl[0] !== 1'b1) lowc++;
        end
        check_val("disabled tx low cycles", lowc, 0);
        check_val("disabled pop count", npop[0] - c0, 1);
        en[0] = 1'b1;
        wait_pop(0, "11");
        capture(0, 10, 0, bits, unst, bcnt);
        check_val("11 frame", {20'd0, bits}, {20'd0, exp_frame(8'h11, 0)});

        // reset asserted mid data bit 5
        @(negedge clk);
        push(0, 8'h5A);
        wait_pop(0, "5A");
        repeat (65) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("async reset tx",   {31'd0, txl[0]}, 32'd1);
        check_val("async reset busy", {31'd0, bsy[0]}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        c0 = npop[0];
        lowc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (txl[0] !== 1'b1) lowc++;
        end
        check_val("post reset tx low cycles", lowc, 0);
        check_val("post reset empty pops", npop[0] - c0, 0);
        push(0, 8'h96);
        wait_pop(0, "96");
        capture(0, 10, 0, bits, unst, bcnt);
        check_val("96 frame", {20'd0, bits}, {20'd0, exp_frame(8'h96, 0)});
        check_val("96 busy cycles", bcnt, 100);
        @(negedge clk);

        check_val("pops while empty", bad[0] + bad[1] + bad[2] + bad[3], 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
